inst_fetch_unit: RTL and testbench

- Instruction-fetch stage that sits directly upstream of the opcode/funct3 decoder (controller) in the RV32 core.
- Holds the program counter and fetches 32-bit words from instruction memory over a req/ready handshake.
- Presents the fetched instruction with a valid/accept handshake, plus pre-sliced op[6:0] and fun[2:0] fields that feed the controller.
- Accepts PC redirects from the branch/jump resolution logic and counts retired fetches.

---
 rtl/inst_fetch_unit.sv | 67 ++++++
 tb/tb_inst_fetch_unit.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: PC-holding fetch stage with req/ready memory handshake and valid/accept output
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_accept,
  output logic [31:0] inst,
  output logic [31:0] pc_out,
  output logic [6:0]  op,
  output logic [2:0]  fun,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] fetch_count
);
  typedef enum logic {FETCH, HOLD} state_t;
  state_t state, state_n;
  logic [31:0] pc, pc_n, inst_n, pc_out_n, count_n;
  assign imem_req   = !rst && state == FETCH;
  assign imem_addr  = pc;
  assign inst_valid = state == HOLD;
  assign op         = inst[6:0];
  assign fun        = inst[14:12];
  // redirect outranks both handshakes and discards any data returned with it
  always_comb begin
    state_n  = state;
    pc_n     = pc;
    inst_n   = inst;
    pc_out_n = pc_out;
    count_n  = fetch_count;
    if (redirect) begin
      state_n = FETCH;
      pc_n    = {redirect_pc[31:2], 2'b00};
      inst_n  = NOP_INST;
    end else if (state == FETCH && imem_ready) begin
      state_n  = HOLD;
      pc_n     = pc + 32'd4;
      inst_n   = imem_rdata;
      pc_out_n = pc;
    end else if (state == HOLD && inst_accept) begin
      state_n = FETCH;
      inst_n  = NOP_INST;
      count_n = fetch_count + 32'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      inst        <= NOP_INST;
      pc_out      <= RESET_PC;
      fetch_count <= '0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      inst        <= inst_n;
      pc_out      <= pc_out_n;
      fetch_count <= count_n;
    end
  end
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: directed stimulus checked every cycle against a transaction-level fetch model
module tb_inst_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 0, rst = 1, imem_ready = 0, inst_accept = 0, redirect = 0;
  logic [31:0] imem_rdata = 0, redirect_pc = 0;
  logic imem_req, inst_valid, imem_req2, inst_valid2;
  logic [31:0] imem_addr, inst, pc_out, fetch_count;
  logic [31:0] imem_addr2, inst2, pc_out2, fetch_count2;
  logic [6:0] op, op2;
  logic [2:0] fun, fun2;
  int total = 0, passed = 0;
  bit chk_en = 0;
  logic m_valid;
  logic [31:0] m_pc, m_inst, m_pc_out, m_cnt;

  always #5 clk = ~clk;

  inst_fetch_unit dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .inst_valid(inst_valid),
    .inst_accept(inst_accept), .inst(inst), .pc_out(pc_out), .op(op), .fun(fun),
    .redirect(redirect), .redirect_pc(redirect_pc), .fetch_count(fetch_count));

  inst_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst(rst), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .inst_valid(inst_valid2),
    .inst_accept(inst_accept), .inst(inst2), .pc_out(pc_out2), .op(op2), .fun(fun2),
    .redirect(redirect), .redirect_pc(redirect_pc), .fetch_count(fetch_count2));

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Transaction view: either waiting for a word, or holding one for the consumer
  always @(posedge clk) begin
    if (rst) begin
      m_valid <= 0; m_pc <= 0; m_inst <= NOP; m_pc_out <= 0; m_cnt <= 0;
    end else if (redirect) begin
      m_valid <= 0; m_inst <= NOP; m_pc <= redirect_pc & ~32'd3;
    end else if (!m_valid && imem_ready) begin
      m_valid <= 1; m_inst <= imem_rdata; m_pc_out <= m_pc; m_pc <= m_pc + 32'd4;
    end else if (m_valid && inst_accept) begin
      m_valid <= 0; m_inst <= NOP; m_cnt <= m_cnt + 32'd1;
    end
  end

  always @(negedge clk) if (chk_en) begin
    cmp("imem_req", {31'd0, imem_req}, {31'd0, !rst && !m_valid});
    if (!m_valid) cmp("imem_addr", imem_addr, m_pc);
    cmp("inst_valid", {31'd0, inst_valid}, {31'd0, m_valid});
    cmp("inst", inst, m_inst);
    cmp("pc_out", pc_out, m_pc_out);
    cmp("op", {25'd0, op}, {25'd0, m_inst[6:0]});
    cmp("fun", {29'd0, fun}, {29'd0, m_inst[14:12]});
    cmp("fetch_count", fetch_count, m_cnt);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tick();
    chk_en = 1;
    tick();
    cmp("rst_req", {31'd0, imem_req}, 32'd0);
    cmp("rst_inst", inst, 32'h0000_0013);
    cmp("rst_op", {25'd0, op}, 32'h13);
    cmp("rst_valid", {31'd0, inst_valid}, 32'd0);
    cmp("rst_count", fetch_count, 32'd0);
    rst = 0; imem_ready = 1; inst_accept = 1; imem_rdata = 32'h00A00093;
    #1 cmp("t1_addr0", imem_addr, 32'd0);
    cmp("t1_req0", {31'd0, imem_req}, 32'd1);
    tick();
    cmp("t1_valid1", {31'd0, inst_valid}, 32'd1);
    cmp("t1_op", {25'd0, op}, 32'h13);
    cmp("t1_fun", {29'd0, fun}, 32'd0);
    cmp("wrap_pc_out", pc_out2, 32'hFFFF_FFFC);
    tick();
    cmp("t1_valid2", {31'd0, inst_valid}, 32'd0);
    cmp("t1_addr4", imem_addr, 32'd4);
    cmp("wrap_addr", imem_addr2, 32'd0);
    tick(); tick();
    cmp("t1_addr8", imem_addr, 32'd8);
    cmp("t1_count2", fetch_count, 32'd2);
    imem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      cmp("t2_addr", imem_addr, 32'd8);
      cmp("t2_req", {31'd0, imem_req}, 32'd1);
      cmp("t2_valid", {31'd0, inst_valid}, 32'd0);
    end
    imem_ready = 1; inst_accept = 0; imem_rdata = 32'h00208033;
    tick();
    imem_ready = 0; imem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      tick();
      cmp("t3_inst", inst, 32'h00208033);
      cmp("t3_pc_out", pc_out, 32'd8);
      cmp("t3_op", {25'd0, op}, 32'h33);
      cmp("t3_req", {31'd0, imem_req}, 32'd0);
      cmp("t3_count", fetch_count, 32'd2);
    end
    inst_accept = 1;
    tick();
    cmp("t3_count3", fetch_count, 32'd3);
    inst_accept = 0; imem_ready = 1; redirect = 1; redirect_pc = 32'h0000_0102;
    tick();
    cmp("t4_valid", {31'd0, inst_valid}, 32'd0);
    cmp("t4_addr", imem_addr, 32'h100);
    cmp("t4_count", fetch_count, 32'd3);
    redirect = 0; imem_rdata = 32'h0040_0113;
    tick();
    cmp("t4_pc_out", pc_out, 32'h100);
    cmp("t4_inst", inst, 32'h0040_0113);
    inst_accept = 1; redirect = 1; redirect_pc = 32'h0000_0203;
    tick();
    cmp("t4b_count", fetch_count, 32'd3);
    cmp("t4b_addr", imem_addr, 32'h200);
    redirect = 0; inst_accept = 0;
    tick();
    cmp("t5_valid", {31'd0, inst_valid}, 32'd1);
    rst = 1;
    #1 cmp("t5_req_rst", {31'd0, imem_req}, 32'd0);
    tick();
    cmp("t5_valid0", {31'd0, inst_valid}, 32'd0);
    cmp("t5_inst", inst, 32'h0000_0013);
    cmp("t5_req", {31'd0, imem_req}, 32'd0);
    cmp("t5_count", fetch_count, 32'd0);
    rst = 0;
    #1 cmp("t5_addr", imem_addr, 32'd0);
    cmp("t5_req1", {31'd0, imem_req}, 32'd1);
    tick(); tick();
    chk_en = 0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
